pipelined_memory: RTL and testbench

PIPELINED_MEMORY -- requirements
Module: pipelined_memory

---
 rtl/pipelined_memory.sv | 192 +++++++++++++++++++
 tb/tb_pipelined_memory.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_memory.sv
// pipelined_memory
//   Single-port word memory with byte-lane writes, a fixed-latency read
//   pipeline and a hardware clear sweep.
//
//   Parameters
//     DATA_W  data word width, multiple of 8
//     ADDR_W  address width; DEPTH = 2**ADDR_W words
//     RD_LAT  read latency in clocks, 1..4
//
//   Ports
//     clk          sole clock, rising edge
//     reset_n      asynchronous active-low reset (memory contents not reset)
//     init         start a clear sweep (ignored while busy)
//     rd / wr      read / write request, accepted only when idle
//     addr         word address
//     wr_data      write data
//     be           byte-lane write enables
//     rd_data      read data, held while rd_valid is low
//     rd_valid     rd_data valid, RD_LAT cycles after an accepted rd
//     busy         clear sweep in progress
//     cmd_dropped  one-cycle pulse after a rd or wr was ignored
//     parity_err   read parity mismatch, qualified by rd_valid
//
//   Build option
//     PIPELINED_MEMORY_PARITY_EN  adds one even-parity bit per byte lane
//     (array par_mem), checked on read. Undefined: parity_err is 0.

module pipelined_memory #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned RD_LAT = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              init,
    input  logic              rd,
    input  logic              wr,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [DATA_W/8-1:0] be,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              busy,
    output logic              cmd_dropped,
    output logic              parity_err
);

    localparam int unsigned NB    = DATA_W / 8;
    localparam int unsigned DEPTH = 1 << ADDR_W;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] sweep_addr, sweep_addr_nxt;
    logic              cmd_acc;
    logic              rd_acc;
    logic              wr_acc;
    logic              drop_nxt;

    logic [DATA_W-1:0] mem [DEPTH];

    logic [RD_LAT-1:0] pipe_v;
    logic [DATA_W-1:0] pipe_d [RD_LAT];

`ifdef PIPELINED_MEMORY_PARITY_EN
    logic [NB-1:0]     par_mem [DEPTH];
    logic [NB-1:0]     pipe_p  [RD_LAT];
`endif

    // ------------------------------------------------------------------
    // Control FSM: commands are only accepted in IDLE when no init is
    // being accepted in the same cycle.
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt      = state;
        sweep_addr_nxt = sweep_addr;
        cmd_acc        = 1'b0;
        case (state)
            IDLE: begin
                if (init) begin
                    state_nxt      = CLEAR;
                    sweep_addr_nxt = '0;
                end else begin
                    cmd_acc = 1'b1;
                end
            end
            CLEAR: begin
                // counter holds at DEPTH-1 on the last sweep write
                if (&sweep_addr) begin
                    state_nxt = IDLE;
                end else begin
                    sweep_addr_nxt = sweep_addr + ADDR_W'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign rd_acc   = rd & cmd_acc;
    assign wr_acc   = wr & cmd_acc;
    assign drop_nxt = (rd | wr) & ~cmd_acc;
    assign busy     = (state == CLEAR);

    // ------------------------------------------------------------------
    // Memory array write port (no reset on contents)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (state == CLEAR) begin
            mem[sweep_addr] <= '0;
`ifdef PIPELINED_MEMORY_PARITY_EN
            par_mem[sweep_addr] <= '0;
`endif
        end else if (wr_acc) begin
            for (int unsigned i = 0; i < NB; i++) begin
                if (be[i]) begin
                    mem[addr][i*8 +: 8] <= wr_data[i*8 +: 8];
`ifdef PIPELINED_MEMORY_PARITY_EN
                    par_mem[addr][i] <= ^wr_data[i*8 +: 8];
`endif
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // State, sweep counter, drop flag and read pipeline.
    // Stage 0 samples mem[addr] on the accepting edge; since the write
    // port updates with non-blocking assignment, a same-cycle rd/wr to
    // one address returns the old word. Each stage only loads data when
    // its upstream stage is valid, so the last stage (rd_data) holds its
    // value between valid pulses.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            sweep_addr  <= '0;
            cmd_dropped <= 1'b0;
            pipe_v      <= '0;
            for (int unsigned i = 0; i < RD_LAT; i++) begin
                pipe_d[i] <= '0;
`ifdef PIPELINED_MEMORY_PARITY_EN
                pipe_p[i] <= '0;
`endif
            end
        end else begin
            state       <= state_nxt;
            sweep_addr  <= sweep_addr_nxt;
            cmd_dropped <= drop_nxt;

            pipe_v[0] <= rd_acc;
            if (rd_acc) begin
                pipe_d[0] <= mem[addr];
`ifdef PIPELINED_MEMORY_PARITY_EN
                pipe_p[0] <= par_mem[addr];
`endif
            end
            for (int unsigned i = 1; i < RD_LAT; i++) begin
                pipe_v[i] <= pipe_v[i-1];
                if (pipe_v[i-1]) begin
                    pipe_d[i] <= pipe_d[i-1];
`ifdef PIPELINED_MEMORY_PARITY_EN
                    pipe_p[i] <= pipe_p[i-1];
`endif
                end
            end
        end
    end

    assign rd_data  = pipe_d[RD_LAT-1];
    assign rd_valid = pipe_v[RD_LAT-1];

`ifdef PIPELINED_MEMORY_PARITY_EN
    logic par_mismatch;

    always_comb begin
        par_mismatch = 1'b0;
        for (int unsigned i = 0; i < NB; i++) begin
            if ((^rd_data[i*8 +: 8]) != pipe_p[RD_LAT-1][i]) begin
                par_mismatch = 1'b1;
            end
        end
    end

    assign parity_err = rd_valid & par_mismatch;
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_pipelined_memory.sv
// tb_pipelined_memory
//   Directed bench for pipelined_memory. Two instances share the command
//   bus: dut_b (ADDR_W=16) and dut_s (ADDR_W=4), both RD_LAT=3, with
//   separate init and reset so the small one can run full clear sweeps.

module tb_pipelined_memory;

    logic        clk;
    logic        rst_b, rst_s;
    logic        init_b, init_s;
    logic        rd, wr;
    logic [15:0] addr;
    logic [15:0] wr_data;
    logic [1:0]  be;

    logic [15:0] b_rd_data, s_rd_data;
    logic        b_rd_valid, s_rd_valid;
    logic        b_busy, s_busy;
    logic        b_drop, s_drop;
    logic        b_perr, s_perr;

    int total = 0;
    int bad   = 0;

    pipelined_memory #(.DATA_W(16), .ADDR_W(16), .RD_LAT(3)) dut_b (
        .clk(clk), .reset_n(rst_b), .init(init_b), .rd(rd), .wr(wr),
        .addr(addr), .wr_data(wr_data), .be(be),
        .rd_data(b_rd_data), .rd_valid(b_rd_valid), .busy(b_busy),
        .cmd_dropped(b_drop), .parity_err(b_perr)
    );

    pipelined_memory #(.DATA_W(16), .ADDR_W(4), .RD_LAT(3)) dut_s (
        .clk(clk), .reset_n(rst_s), .init(init_s), .rd(rd), .wr(wr),
        .addr(addr[3:0]), .wr_data(wr_data), .be(be),
        .rd_data(s_rd_data), .rd_valid(s_rd_valid), .busy(s_busy),
        .cmd_dropped(s_drop), .parity_err(s_perr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] o_data(input logic s);
        return s ? s_rd_data : b_rd_data;
    endfunction

    function automatic logic o_valid(input logic s);
        return s ? s_rd_valid : b_rd_valid;
    endfunction

    function automatic logic o_perr(input logic s);
        return s ? s_perr : b_perr;
    endfunction

    task automatic do_write(input logic [15:0] a, input logic [15:0] d, input logic [1:0] lanes);
        wr = 1'b1; addr = a; wr_data = d; be = lanes;
        tick();
        wr = 1'b0;
    endtask

    // rd in cycle c; rd_valid low in c+1 and c+2, high in c+3, low in c+4
    task automatic do_read(input logic s, input logic [15:0] a, input logic [15:0] exp, input string tag);
        rd = 1'b1; addr = a;
        tick();
        rd = 1'b0;
        chk({tag, "_v1"}, 32'(o_valid(s)), 32'd0);
        tick();
        chk({tag, "_v2"}, 32'(o_valid(s)), 32'd0);
        tick();
        chk({tag, "_v3"}, 32'(o_valid(s)), 32'd1);
        chk({tag, "_data"}, 32'(o_data(s)), 32'(exp));
        chk({tag, "_perr"}, 32'(o_perr(s)), 32'd0);
        tick();
        chk({tag, "_v4"}, 32'(o_valid(s)), 32'd0);
        chk({tag, "_hold"}, 32'(o_data(s)), 32'(exp));
    endtask

    initial begin
        int busy_cnt;
        int drop_cnt;
        int sval_cnt;

        rst_b = 1'b0; rst_s = 1'b0; init_b = 1'b0; init_s = 1'b0;
        rd = 1'b0; wr = 1'b0; addr = '0; wr_data = '0; be = '0;

        // reset state
        tick();
        tick();
        chk("rst_valid", 32'(b_rd_valid), 32'd0);
        chk("rst_data", 32'(b_rd_data), 32'd0);
        chk("rst_busy", 32'(b_busy), 32'd0);
        chk("rst_drop", 32'(b_drop), 32'd0);
        chk("rst_perr", 32'(b_perr), 32'd0);
        chk("rst_s_busy", 32'(s_busy), 32'd0);
        rst_b = 1'b1; rst_s = 1'b1;
        tick();

        // basic write/read with latency 3
        do_write(16'h0010, 16'hA5C3, 2'b11);
        do_read(1'b0, 16'h0010, 16'hA5C3, "rd_a5c3");

        // byte-lane write: only lane 0 updated
        do_write(16'h0020, 16'h1234, 2'b11);
        do_write(16'h0020, 16'hFFFF, 2'b01);
        do_read(1'b0, 16'h0020, 16'h12FF, "rd_lane");

        // same-cycle rd and wr: read-before-write
        do_write(16'h0030, 16'hAAAA, 2'b11);
        rd = 1'b1; wr = 1'b1; addr = 16'h0030; wr_data = 16'h5555; be = 2'b11;
        tick();
        rd = 1'b0; wr = 1'b0;
        tick();
        tick();
        chk("rbw_valid", 32'(b_rd_valid), 32'd1);
        chk("rbw_old", 32'(b_rd_data), 32'h0000AAAA);
        tick();
        do_read(1'b0, 16'h0030, 16'h5555, "rbw_new");

        // back-to-back reads: rd pattern 1,1,0,1 -> rd_valid same pattern +3
        rd = 1'b1; addr = 16'h0010;
        tick();
        addr = 16'h0020;
        tick();
        rd = 1'b0;
        tick();
        chk("b2b_v0", 32'(b_rd_valid), 32'd1);
        chk("b2b_d0", 32'(b_rd_data), 32'h0000A5C3);
        rd = 1'b1; addr = 16'h0030;
        tick();
        rd = 1'b0;
        chk("b2b_v1", 32'(b_rd_valid), 32'd1);
        chk("b2b_d1", 32'(b_rd_data), 32'h000012FF);
        tick();
        chk("b2b_v2", 32'(b_rd_valid), 32'd0);
        tick();
        chk("b2b_v3", 32'(b_rd_valid), 32'd1);
        chk("b2b_d3", 32'(b_rd_data), 32'h00005555);
        tick();

        // small instance: fill, sweep with dropped rd and ignored re-init
        for (int i = 0; i < 16; i++) do_write(16'(i), 16'hBEEF, 2'b11);
        init_s = 1'b1;
        tick();
        init_s = 1'b0;
        busy_cnt = 0; drop_cnt = 0; sval_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            if (s_busy) busy_cnt++;
            if (s_drop) drop_cnt++;
            if (s_rd_valid) sval_cnt++;
            if (i == 15) chk("sweep_busy_last", 32'(s_busy), 32'd1);
            if (i == 16) chk("sweep_busy_end", 32'(s_busy), 32'd0);
            rd = (i == 1); addr = 16'h0005;
            init_s = (i == 5);
            tick();
        end
        rd = 1'b0; init_s = 1'b0;
        chk("sweep_busy_cnt", 32'(busy_cnt), 32'd16);
        chk("sweep_drop_cnt", 32'(drop_cnt), 32'd1);
        chk("sweep_no_valid", 32'(sval_cnt), 32'd0);
        for (int i = 0; i < 16; i++) do_read(1'b1, 16'(i), 16'h0000, "sweep_zero");

        // reset mid-sweep at address 8
        do_write(16'h0003, 16'h7777, 2'b11);
        do_write(16'h000C, 16'h7777, 2'b11);
        init_s = 1'b1;
        tick();
        init_s = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        rst_s = 1'b0;
        #1;
        chk("abort_busy", 32'(s_busy), 32'd0);
        chk("abort_valid", 32'(s_rd_valid), 32'd0);
        tick();
        rst_s = 1'b1;
        wr = 1'b1; addr = 16'h000E; wr_data = 16'h1111; be = 2'b11;
        tick();
        wr = 1'b0;
        chk("abort_idle_nodrop", 32'(s_drop), 32'd0);
        do_read(1'b1, 16'h0003, 16'h0000, "abort_a3");
        do_read(1'b1, 16'h000C, 16'h7777, "abort_a12");

        // read accepted before init completes; wr with init is dropped
        rd = 1'b1; addr = 16'h000E;
        tick();
        rd = 1'b0;
        init_s = 1'b1; wr = 1'b1; addr = 16'h0002; wr_data = 16'h9999;
        tick();
        init_s = 1'b0; wr = 1'b0;
        chk("init_wr_drop", 32'(s_drop), 32'd1);
        chk("pre_init_v0", 32'(s_rd_valid), 32'd0);
        tick();
        chk("pre_init_v1", 32'(s_rd_valid), 32'd1);
        chk("pre_init_data", 32'(s_rd_data), 32'h00001111);
        chk("init_drop_once", 32'(s_drop), 32'd0);
        for (int i = 0; i < 14; i++) tick();
        chk("sweep2_busy_last", 32'(s_busy), 32'd1);
        tick();
        chk("sweep2_busy_end", 32'(s_busy), 32'd0);
        do_read(1'b1, 16'h0002, 16'h0000, "sweep2_a2");

`ifdef PIPELINED_MEMORY_PARITY_EN
        // corrupted lane-0 parity bit must flag parity_err with rd_valid
        do_write(16'h0040, 16'h00FF, 2'b11);
        dut_b.par_mem[16'h0040][0] = ~dut_b.par_mem[16'h0040][0];
        rd = 1'b1; addr = 16'h0040;
        tick();
        rd = 1'b0;
        tick();
        tick();
        chk("par_valid", 32'(b_rd_valid), 32'd1);
        chk("par_data", 32'(b_rd_data), 32'h000000FF);
        chk("par_err", 32'(b_perr), 32'd1);
        tick();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
